melody_sequencer: RTL and testbench

Score-playback controller for the buzzer path: walks a melody ROM entry by entry and drives the combinational beat decoder with each entry's beat code. It times each note for the decoder's returned cycle count, presents the note's tune code to the tone generator with an articulation gap, and handles start/stop/pause and looping. It sits between the game-event logic (start/stop requests) and the buzzer tone/PWM stage.

---
 rtl/melody_sequencer.sv | 113 +++++++++++
 tb/tb_melody_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_sequencer.sv
// Score-playback controller: walks the melody ROM, times each note from the
// beat decoder's cycle count and drives the tone generator with an articulation gap.
module melody_sequencer #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned TUNE_W     = 8,
    parameter logic [27:0] GAP_CYCLES = 28'd1_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              pause,
    input  logic              loop_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TUNE_W+3:0] rom_data,
    output logic [3:0]        beat_code,
    input  logic [27:0]       beat_cnt_parameter,
    output logic [TUNE_W-1:0] tone_code,
    output logic              note_on,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        DECODE,
        PLAY,
        DONE
    } state_t;

    state_t            state;
    logic [27:0]       cnt;
    logic [TUNE_W-1:0] tune_q;
    logic              note_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rom_addr  <= '0;
            beat_code <= '0;
            tone_code <= '0;
            tune_q    <= '0;
            cnt       <= '0;
            note_en   <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state     <= IDLE;
                rom_addr  <= '0;
                beat_code <= '0;
                tone_code <= '0;
                note_en   <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            rom_addr <= '0;
                            state    <= FETCH;
                        end
                    end
                    FETCH: state <= LATCH;
                    LATCH: begin
                        if (rom_data[3:0] == 4'd0) begin
                            if (loop_en) begin
                                rom_addr <= '0;
                                state    <= FETCH;
                            end else begin
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end else begin
                            beat_code <= rom_data[3:0];
                            tune_q    <= rom_data[TUNE_W+3:4];
                            state     <= DECODE;
                        end
                    end
                    DECODE: begin
                        // A zero duration marks an illegal beat code: skip the entry.
                        if (beat_cnt_parameter == 28'd0) begin
                            rom_addr <= rom_addr + 1'b1;
                            state    <= FETCH;
                        end else begin
                            cnt       <= beat_cnt_parameter - 28'd1;
                            tone_code <= tune_q;
                            note_en   <= (tune_q != '0);
                            state     <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (!pause) begin
                            if (cnt == 28'd0) begin
                                rom_addr <= rom_addr + 1'b1;
                                note_en  <= 1'b0;
                                state    <= FETCH;
                            end else begin
                                cnt <= cnt - 28'd1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Registered note enable, gated in the same cycle by pause and the trailing gap.
    assign note_on = note_en && (state == PLAY) && !pause && (cnt >= GAP_CYCLES);
    assign busy    = (state != IDLE) && (state != DONE);

endmodule

// File: tb/tb_melody_sequencer.sv
// Randomized self-checking bench: predicts a per-cycle output timeline from
// the score contents and compares it against melody_sequencer.
module tb_melody_sequencer;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, pause, loop_en;
    logic [7:0]  rom_addr;
    logic [11:0] rom_data;
    logic [3:0]  beat_code;
    logic [27:0] beat_cnt_parameter;
    logic [7:0]  tone_code;
    logic        note_on, busy, done;

    logic [11:0] mem [256];

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] beat;
        logic [7:0] tone;
        logic       note;
        logic       busy;
        logic       done;
    } exp_t;

    exp_t tl[$];
    bit   pm[$];
    int   done_idx;
    int   checks = 0;
    int   errors = 0;

    melody_sequencer #(
        .ADDR_W(8),
        .TUNE_W(8),
        .GAP_CYCLES(28'd2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .stop(stop),
        .pause(pause),
        .loop_en(loop_en),
        .rom_addr(rom_addr),
        .rom_data(rom_data),
        .beat_code(beat_code),
        .beat_cnt_parameter(beat_cnt_parameter),
        .tone_code(tone_code),
        .note_on(note_on),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= mem[rom_addr];

    function automatic logic [27:0] dec(input logic [3:0] b);
        case (b)
            4'd1:    dec = 28'd4;
            4'd2:    dec = 28'd6;
            4'd3:    dec = 28'd10;
            4'd4:    dec = 28'd20;
            4'd5:    dec = 28'd5;
            4'd6:    dec = 28'd3;
            default: dec = 28'd0;
        endcase
    endfunction

    assign beat_cnt_parameter = dec(beat_code);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t e, input bit p);
        tl.push_back(e);
        pm.push_back(p);
    endtask

    // Expected outputs, one entry per cycle; cycle 0 is the cycle start is driven.
    task automatic build_timeline(input int pk, input int po, input int plen);
        exp_t        e;
        int unsigned addr;
        int          note_idx;
        int          dur;
        logic [11:0] word;
        tl.delete();
        pm.delete();
        e = '0;
        push(e, 1'b0);
        addr     = 0;
        note_idx = 0;
        done_idx = 0;
        for (int n = 0; n < 256; n++) begin
            word   = mem[addr];
            e.addr = 8'(addr);
            e.note = 1'b0;
            e.busy = 1'b1;
            e.done = 1'b0;
            push(e, 1'b0);
            push(e, 1'b0);
            if (word[3:0] == 4'd0) begin
                e.busy   = 1'b0;
                e.done   = 1'b1;
                done_idx = tl.size();
                push(e, 1'b0);
                e.done = 1'b0;
                repeat (3) push(e, 1'b0);
                return;
            end
            e.beat = word[3:0];
            push(e, 1'b0);
            dur  = int'(dec(word[3:0]));
            addr = (addr + 1) % 256;
            if (dur == 0) continue;
            e.tone = word[11:4];
            for (int i = 0; i < dur; i++) begin
                if (note_idx == pk && i == po) begin
                    e.note = 1'b0;
                    repeat (plen) push(e, 1'b1);
                end
                e.note = (e.tone != 8'h00) && ((dur - 1 - i) >= GAP);
                push(e, 1'b0);
            end
            note_idx++;
        end
    endtask

    task automatic run_timeline(input string name, input int xs);
        exp_t e;
        for (int k = 0; k < tl.size(); k++) begin
            start = (k == 0) || (k == xs);
            pause = pm[k];
            e = tl[k];
            @(negedge clk);
            chk($sformatf("%s c%0d rom_addr", name, k), 32'(rom_addr), 32'(e.addr));
            chk($sformatf("%s c%0d beat_code", name, k), 32'(beat_code), 32'(e.beat));
            chk($sformatf("%s c%0d tone_code", name, k), 32'(tone_code), 32'(e.tone));
            chk($sformatf("%s c%0d note_on", name, k), 32'(note_on), 32'(e.note));
            chk($sformatf("%s c%0d busy", name, k), 32'(busy), 32'(e.busy));
            chk($sformatf("%s c%0d done", name, k), 32'(done), 32'(e.done));
            step();
        end
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic do_stop(input string name);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk({name, " stop busy"}, 32'(busy), 32'd0);
        chk({name, " stop note_on"}, 32'(note_on), 32'd0);
        chk({name, " stop rom_addr"}, 32'(rom_addr), 32'd0);
        chk({name, " stop beat_code"}, 32'(beat_code), 32'd0);
        chk({name, " stop tone_code"}, 32'(tone_code), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          n, pk, po, plen, xs, dcnt, bcnt;
        logic [3:0]  b;
        logic [7:0]  tn;
        int          pdur[$];

        for (int i = 0; i < 256; i++) mem[i] = 12'h000;
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        pause   = 1'b0;
        loop_en = 1'b0;
        #2;
        chk("reset rom_addr", 32'(rom_addr), 32'd0);
        chk("reset beat_code", 32'(beat_code), 32'd0);
        chk("reset tone_code", 32'(tone_code), 32'd0);
        chk("reset note_on", 32'(note_on), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        step();
        step();
        rst_n = 1'b1;

        mem[0] = 12'h113; mem[1] = 12'h004; mem[2] = 12'h220;
        do_stop("song1");
        build_timeline(-1, 0, 0);
        run_timeline("song1", -1);

        mem[0] = 12'h337; mem[1] = 12'h443; mem[2] = 12'h000;
        do_stop("skip");
        build_timeline(-1, 0, 0);
        run_timeline("skip", -1);

        mem[0] = 12'h113; mem[1] = 12'h000;
        do_stop("pause");
        build_timeline(0, 3, 5);
        run_timeline("pause", -1);

        mem[0] = 12'h774; mem[1] = 12'h000;
        do_stop("busystart");
        build_timeline(-1, 0, 0);
        run_timeline("busystart", 8);

        for (int it = 0; it < 24; it++) begin
            n = int'($urandom_range(1, 5));
            pdur.delete();
            for (int i = 0; i < n; i++) begin
                b  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(1, 6));
                tn = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                mem[i] = {tn, b};
                if (dec(b) != 28'd0) pdur.push_back(int'(dec(b)));
            end
            mem[n] = {8'($urandom_range(0, 255)), 4'h0};
            pk = -1; po = 0; plen = 0;
            if (pdur.size() > 0 && $urandom_range(0, 1) == 1) begin
                pk   = int'($urandom_range(0, pdur.size() - 1));
                po   = int'($urandom_range(0, pdur[pk] - 1));
                plen = int'($urandom_range(1, 5));
            end
            build_timeline(pk, po, plen);
            xs = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, done_idx - 1)) : -1;
            do_stop($sformatf("rnd%0d", it));
            run_timeline($sformatf("rnd%0d", it), xs);
        end

        mem[0] = 12'h553; mem[1] = 12'h663; mem[2] = 12'h000;
        do_stop("loop");
        loop_en = 1'b1;
        dcnt = 0;
        for (int k = 0; k <= 33; k++) begin
            start = (k == 0);
            @(negedge clk);
            if (done) dcnt++;
            if (k == 28) chk("loop marker rom_addr", 32'(rom_addr), 32'd2);
            if (k == 29) chk("loop wrap rom_addr", 32'(rom_addr), 32'd0);
            if (k == 29) chk("loop wrap busy", 32'(busy), 32'd1);
            if (k == 33) chk("loop replay note_on", 32'(note_on), 32'd1);
            step();
        end
        start = 1'b0;
        stop  = 1'b1;
        step();
        stop = 1'b0;
        chk("loop stop busy", 32'(busy), 32'd0);
        chk("loop stop note_on", 32'(note_on), 32'd0);
        chk("loop stop rom_addr", 32'(rom_addr), 32'd0);
        chk("loop done count", 32'(dcnt), 32'd0);
        loop_en = 1'b0;

        do_stop("startstop");
        start = 1'b1;
        stop  = 1'b1;
        step();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop busy", 32'(busy), 32'd0);
        step();
        chk("startstop busy+1", 32'(busy), 32'd0);
        chk("startstop rom_addr", 32'(rom_addr), 32'd0);

        mem[0] = 12'h113; mem[1] = 12'h000;
        do_stop("rst");
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("rst pre note_on", 32'(note_on), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async note_on", 32'(note_on), 32'd0);
        chk("rst async busy", 32'(busy), 32'd0);
        chk("rst async done", 32'(done), 32'd0);
        chk("rst async tone_code", 32'(tone_code), 32'd0);
        chk("rst async beat_code", 32'(beat_code), 32'd0);
        chk("rst async rom_addr", 32'(rom_addr), 32'd0);
        step();
        rst_n = 1'b1;
        dcnt = 0;
        bcnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) dcnt++;
            if (busy || note_on) bcnt++;
            step();
        end
        chk("rst no resume", 32'(bcnt), 32'd0);
        chk("rst no done", 32'(dcnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
